// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: double-buffered sprite line renderer with clear-after-read readout
module sprite_line_buffer #(
  parameter int XW = 8,
  parameter int PW = 4
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          cen_6m,
  input  logic          line_strobe,
  input  logic          hblank,
  input  logic [7:0]    hcnt,
  input  logic          ocs_n,
  input  logic          oflp,
  input  logic          ocol_n,
  input  logic          odat_n,
  input  logic [7:0]    ob,
  input  logic [PW-1:0] spr_pix,
  output logic [7:0]    spr_out
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic r_wbank, r_dir;
  logic [3:0] r_cbank, r_rcbank, r_cnt;
  logic [XW-1:0] r_waddr;
  logic [7:0] r_spr_out;
  logic [7:0] r_mem0 [0:2**XW-1];
  logic [7:0] r_mem1 [0:2**XW-1];
  logic w_start, w_step, w_wr, w_rd;
  logic [XW-1:0] w_raddr;
  logic [7:0] w_wdata, w_rdata;
  assign w_start = !ocol_n && !ocs_n;
  assign w_raddr = XW'(hcnt);
  always_ff @(posedge clk_49m or posedge reset)
    if (reset) r_state <= IDLE;
    else if (cen_6m) r_state <= w_next;
  // a new start always wins; strobe, abort and the 16th pixel all end the run
  always_comb
    w_next = w_start ? RUN :
             (line_strobe || !ocol_n || r_cnt == 4'd15) ? IDLE : r_state;
  always_comb begin
    w_step  = r_state == RUN && ocol_n && !line_strobe;
    w_wr    = w_step && |spr_pix;
    w_rd    = !hblank;
    w_wdata = {r_rcbank, spr_pix};
    w_rdata = r_wbank ? r_mem0[w_raddr] : r_mem1[w_raddr];
  end
  always_ff @(posedge clk_49m or posedge reset)
    if (reset) begin
      r_wbank   <= 1'b0;
      r_cbank   <= 4'd0;
      r_rcbank  <= 4'd0;
      r_cnt     <= 4'd0;
      r_dir     <= 1'b0;
      r_waddr   <= '0;
      r_spr_out <= 8'd0;
    end else if (cen_6m) begin
      if (line_strobe) r_wbank <= ~r_wbank;
      if (!odat_n) r_cbank <= ob[3:0];
      if (w_start) begin
        r_cnt    <= 4'd0;
        r_waddr  <= XW'(ob) + (oflp ? XW'(15) : XW'(0));
        r_dir    <= oflp;
        r_rcbank <= r_cbank;
      end else if (w_step) begin
        r_cnt   <= r_cnt + 4'd1;
        r_waddr <= r_waddr + (r_dir ? '1 : XW'(1));
      end
      r_spr_out <= hblank ? 8'd0 : w_rdata;
    end
  // render port owns bank r_wbank, clear port owns the other bank
  always_ff @(posedge clk_49m)
    if (cen_6m && !reset) begin
      if (r_wbank ? w_rd : w_wr) r_mem0[r_wbank ? w_raddr : r_waddr] <= r_wbank ? 8'd0 : w_wdata;
      if (r_wbank ? w_wr : w_rd) r_mem1[r_wbank ? r_waddr : w_raddr] <= r_wbank ? w_wdata : 8'd0;
    end
  assign spr_out = r_spr_out;
endmodule
